// File: rtl/sysid_pkg.sv
// Shared definitions for the system ID boot checker: FSM states, slave word
// addresses and the build-time expected ID/timestamp values (also consumed by
// the sysid generator so both sides agree on the same constants).
package sysid_pkg;

  typedef enum logic [2:0] {
    DELAY,
    RD_ID,
    RD_TS,
    COMPARE,
    PASS,
    FAIL,
    TIMEOUT_ERR
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] SYSID_EXPECTED_TIMESTAMP = 32'd1326413930;

  // Terminal states wait for a recheck pulse and drive the status outputs.
  function automatic logic is_terminal(input sysid_state_t s);
    return (s == PASS) || (s == FAIL) || (s == TIMEOUT_ERR);
  endfunction

  // Read states hold avm_read high and are watched by the stall timer.
  function automatic logic is_read(input sysid_state_t s);
    return (s == RD_ID) || (s == RD_TS);
  endfunction

endpackage

// File: rtl/avm_read_timeout.sv
// Per-read stall timer. Counts cycles with waitrequest held high during a read;
// expired fires combinationally on the stall cycle that would reach the limit
// so the FSM can leave the read state on that same edge.
module avm_read_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry is the stall cycle that completes the allowed budget.
  always_comb begin
    expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  // Clear has priority so a new read always starts from a full budget.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time system ID checker. Reads the ID and timestamp words from the
// system ID slave over Avalon-MM, compares them with build-time constants and
// only releases the CPU reset once both match. Mismatches are re-read a
// bounded number of times; a stalled bus ends in a timeout error instead.
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_EXPECTED_TIMESTAMP,
  parameter int          START_DELAY        = 16,
  parameter int          TIMEOUT_CYCLES     = 1024,
  parameter int          MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        recheck,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] captured_id,
  output logic [31:0] captured_timestamp,
  output logic        check_done,
  output logic        id_ok,
  output logic        id_mismatch,
  output logic        bus_timeout,
  output logic        cpu_release,
  output logic [1:0]  retry_count
);

  localparam int DW = $clog2(START_DELAY + 2);

  sysid_state_t state_q, state_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [1:0]    retry_q, retry_d;
  logic [31:0]   cap_id_q, cap_id_d;
  logic [31:0]   cap_ts_q, cap_ts_d;
  logic          avm_read_q, avm_read_d;
  logic          avm_addr_q, avm_addr_d;
  logic          check_done_q, check_done_d;
  logic          id_ok_q, id_ok_d;
  logic          id_mismatch_q, id_mismatch_d;
  logic          bus_timeout_q, bus_timeout_d;
  logic          cpu_release_q, cpu_release_d;

  logic          to_clear;
  logic          to_enable;
  logic          to_expired;
  logic          words_match;

  // Stall budget restarts on every entry into a read state, including the
  // direct RD_ID to RD_TS hop and each retry pass.
  always_comb begin
    to_enable = is_read(state_q) && avm_waitrequest;
    to_clear  = is_read(state_d) && (state_d != state_q);
  end

  avm_read_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  // Next-state, capture and retry bookkeeping for the boot check sequence.
  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    retry_d     = retry_q;
    cap_id_d    = cap_id_q;
    cap_ts_d    = cap_ts_q;
    words_match = (cap_id_q == EXPECTED_ID) && (cap_ts_q == EXPECTED_TIMESTAMP);

    case (state_q)
      DELAY: begin
        if ((int'(delay_q) + 1) >= START_DELAY) begin
          delay_d = '0;
          state_d = RD_ID;
        end else begin
          delay_d = delay_q + DW'(1);
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          cap_id_d = avm_readdata;
          state_d  = RD_TS;
        end else if (to_expired) begin
          state_d = TIMEOUT_ERR;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          cap_ts_d = avm_readdata;
          state_d  = COMPARE;
        end else if (to_expired) begin
          state_d = TIMEOUT_ERR;
        end
      end
      COMPARE: begin
        if (words_match) begin
          state_d = PASS;
        end else if (int'(retry_q) < MAX_RETRIES) begin
          retry_d = retry_q + 2'd1;
          state_d = RD_ID;
        end else begin
          state_d = FAIL;
        end
      end
      PASS, FAIL, TIMEOUT_ERR: begin
        if (recheck) begin
          retry_d = 2'd0;
          state_d = RD_ID;
        end
      end
      default: begin
        state_d = DELAY;
      end
    endcase
  end

  // Bus strobes follow the next state so they are registered and line up
  // with the read states; status flags take one extra register stage.
  always_comb begin
    avm_read_d    = is_read(state_d);
    avm_addr_d    = (state_d == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    check_done_d  = is_terminal(state_q);
    id_ok_d       = (state_q == PASS);
    id_mismatch_d = (state_q == FAIL);
    bus_timeout_d = (state_q == TIMEOUT_ERR);
    cpu_release_d = (state_q == PASS);
  end

  // All state, capture and output registers; reset aborts any read at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= DELAY;
      delay_q       <= '0;
      retry_q       <= 2'd0;
      cap_id_q      <= 32'd0;
      cap_ts_q      <= 32'd0;
      avm_read_q    <= 1'b0;
      avm_addr_q    <= 1'b0;
      check_done_q  <= 1'b0;
      id_ok_q       <= 1'b0;
      id_mismatch_q <= 1'b0;
      bus_timeout_q <= 1'b0;
      cpu_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      delay_q       <= delay_d;
      retry_q       <= retry_d;
      cap_id_q      <= cap_id_d;
      cap_ts_q      <= cap_ts_d;
      avm_read_q    <= avm_read_d;
      avm_addr_q    <= avm_addr_d;
      check_done_q  <= check_done_d;
      id_ok_q       <= id_ok_d;
      id_mismatch_q <= id_mismatch_d;
      bus_timeout_q <= bus_timeout_d;
      cpu_release_q <= cpu_release_d;
    end
  end

  assign avm_read           = avm_read_q;
  assign avm_address        = avm_addr_q;
  assign captured_id        = cap_id_q;
  assign captured_timestamp = cap_ts_q;
  assign check_done         = check_done_q;
  assign id_ok              = id_ok_q;
  assign id_mismatch        = id_mismatch_q;
  assign bus_timeout        = bus_timeout_q;
  assign cpu_release        = cpu_release_q;
  assign retry_count        = retry_q;

endmodule
